// File: rtl/vending_fsm_param_if.sv
// ============================================================================
//  vending_fsm_param_if
//  Coin-acceptor / dispenser / change-hopper signal bundle for vending_fsm_param.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface vending_fsm_param_if #(
   parameter int CREDIT_W = 4
);
   logic                coin_valid;
   logic [1:0]          coin_code;
   logic                cancel;
   logic                vend;
   logic                chg_valid;
   logic [CREDIT_W-1:0] chg_amt;
   logic                chg_refund;
   logic                chg_ready;
   logic                coin_rej;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   // Controller side
   modport slave (
      input  coin_valid, coin_code, cancel, chg_ready,
      output vend, chg_valid, chg_amt, chg_refund, coin_rej, credit, busy
   );

   // Front-end / hopper side
   modport master (
      output coin_valid, coin_code, cancel, chg_ready,
      input  vend, chg_valid, chg_amt, chg_refund, coin_rej, credit, busy
   );
endinterface

`default_nettype wire

// File: rtl/vending_fsm_param.sv
// ============================================================================
//  vending_fsm_param
//  Coin-accumulating vending controller with registered vend/change/refund outputs.
//  Rev 1.0
// ============================================================================
`default_nettype none

module vending_fsm_param #(
   parameter int CREDIT_W = 4,
   parameter int PRICE    = 3,
   parameter int COIN_A   = 1,
   parameter int COIN_B   = 2,
   parameter int COIN_C   = 5
) (
   input  wire                  clk,
   input  wire                  rst,
   vending_fsm_param_if.slave   bus
);

   localparam int c_max_ab   = (COIN_A > COIN_B) ? COIN_A : COIN_B;
   localparam int c_max_coin = (c_max_ab > COIN_C) ? c_max_ab : COIN_C;
   localparam int c_max_val  = (2 ** CREDIT_W) - 1;

   localparam logic [CREDIT_W-1:0] c_price  = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] c_coin_a = CREDIT_W'(COIN_A);
   localparam logic [CREDIT_W-1:0] c_coin_b = CREDIT_W'(COIN_B);
   localparam logic [CREDIT_W-1:0] c_coin_c = CREDIT_W'(COIN_C);

   // Credit can never exceed PRICE-1 before a coin lands, so this bound rules out wrap.
   generate
      if ((PRICE < 1) || (PRICE > c_max_val) || ((PRICE - 1 + c_max_coin) > c_max_val))
      begin : g_bad_params
         $error("vending_fsm_param: illegal PRICE/COIN/CREDIT_W combination");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_VEND    = 3'd2,
      S_CHANGE  = 3'd3,
      S_REFUND  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
   logic                vend_q, vend_d;
   logic                chg_valid_q, chg_valid_d;
   logic                chg_refund_q, chg_refund_d;
   logic                coin_rej_q, coin_rej_d;
   logic                busy_q, busy_d;

   logic                coin_present;
   logic                cur_busy;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W-1:0] sum;
   logic [CREDIT_W-1:0] change;

   always_comb begin
      coin_val = '0;
      unique case (bus.coin_code)
         2'b01:   coin_val = c_coin_a;
         2'b10:   coin_val = c_coin_b;
         2'b11:   coin_val = c_coin_c;
         default: coin_val = '0;
      endcase
      if (!bus.coin_valid) begin
         coin_val = '0;
      end
   end

   assign coin_present = bus.coin_valid && (bus.coin_code != 2'b00);
   assign cur_busy     = (state_q == S_VEND) || (state_q == S_CHANGE) || (state_q == S_REFUND);
   assign sum          = credit_q + coin_val;
   assign change       = credit_q - c_price;

   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      chg_amt_d    = chg_amt_q;
      vend_d       = 1'b0;
      chg_valid_d  = chg_valid_q;
      chg_refund_d = chg_refund_q;
      coin_rej_d   = cur_busy && coin_present;

      unique case (state_q)
         S_IDLE, S_COLLECT: begin
            credit_d = sum;
            // Cancel takes priority even when this coin would complete the price.
            if (bus.cancel && (sum != '0)) begin
               state_d      = S_REFUND;
               chg_amt_d    = sum;
               chg_valid_d  = 1'b1;
               chg_refund_d = 1'b1;
            end else if (sum >= c_price) begin
               state_d = S_VEND;
               vend_d  = 1'b1;
            end else if (sum != '0) begin
               state_d = S_COLLECT;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_VEND: begin
            if (change == '0) begin
               state_d  = S_IDLE;
               credit_d = '0;
            end else begin
               state_d      = S_CHANGE;
               chg_amt_d    = change;
               chg_valid_d  = 1'b1;
               chg_refund_d = 1'b0;
            end
         end

         S_CHANGE, S_REFUND: begin
            if (bus.chg_ready) begin
               state_d      = S_IDLE;
               credit_d     = '0;
               chg_amt_d    = '0;
               chg_valid_d  = 1'b0;
               chg_refund_d = 1'b0;
            end
         end

         default: begin
            state_d      = S_IDLE;
            credit_d     = '0;
            chg_amt_d    = '0;
            chg_valid_d  = 1'b0;
            chg_refund_d = 1'b0;
         end
      endcase

      busy_d = (state_d == S_VEND) || (state_d == S_CHANGE) || (state_d == S_REFUND);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         credit_q     <= '0;
         chg_amt_q    <= '0;
         vend_q       <= 1'b0;
         chg_valid_q  <= 1'b0;
         chg_refund_q <= 1'b0;
         coin_rej_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         chg_amt_q    <= chg_amt_d;
         vend_q       <= vend_d;
         chg_valid_q  <= chg_valid_d;
         chg_refund_q <= chg_refund_d;
         coin_rej_q   <= coin_rej_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.vend       = vend_q;
   assign bus.chg_valid  = chg_valid_q;
   assign bus.chg_amt    = chg_amt_q;
   assign bus.chg_refund = chg_refund_q;
   assign bus.coin_rej   = coin_rej_q;
   assign bus.credit     = credit_q;
   assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vending_fsm_param.sv
// ============================================================================
//  tb_vending_fsm_param
//  Directed self-checking bench: default build plus a CREDIT_W=6 / PRICE=20 build.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_vending_fsm_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   vending_fsm_param_if #(.CREDIT_W(4)) a_if ();
   vending_fsm_param_if #(.CREDIT_W(6)) b_if ();

   vending_fsm_param #(
      .CREDIT_W(4), .PRICE(3), .COIN_A(1), .COIN_B(2), .COIN_C(5)
   ) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   vending_fsm_param #(
      .CREDIT_W(6), .PRICE(20), .COIN_A(1), .COIN_B(2), .COIN_C(5)
   ) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // e_amt < 0 means chg_amt is not checked at this point
   task automatic expect_a(input string tag, input logic e_vend, input logic e_cv,
                           input int e_amt, input logic e_ref, input logic e_rej,
                           input int e_credit, input logic e_busy);
      chk({tag, ".vend"},       32'(a_if.vend),       32'(e_vend));
      chk({tag, ".chg_valid"},  32'(a_if.chg_valid),  32'(e_cv));
      if (e_amt >= 0) chk({tag, ".chg_amt"}, 32'(a_if.chg_amt), 32'(e_amt));
      chk({tag, ".chg_refund"}, 32'(a_if.chg_refund), 32'(e_ref));
      chk({tag, ".coin_rej"},   32'(a_if.coin_rej),   32'(e_rej));
      chk({tag, ".credit"},     32'(a_if.credit),     32'(e_credit));
      chk({tag, ".busy"},       32'(a_if.busy),       32'(e_busy));
   endtask

   task automatic drive_a(input logic cv, input logic [1:0] code, input logic can,
                          input logic rdy);
      a_if.coin_valid = cv;
      a_if.coin_code  = code;
      a_if.cancel     = can;
      a_if.chg_ready  = rdy;
   endtask

   initial begin
      drive_a(1'b0, 2'b00, 1'b0, 1'b0);
      b_if.coin_valid = 1'b0;
      b_if.coin_code  = 2'b00;
      b_if.cancel     = 1'b0;
      b_if.chg_ready  = 1'b0;

      // Reset
      rst = 1'b1;
      tick();
      tick();
      expect_a("reset", 0, 0, 0, 0, 0, 0, 0);
      chk("reset_b.credit", 32'(b_if.credit), 32'd0);
      chk("reset_b.busy",   32'(b_if.busy),   32'd0);
      rst = 1'b0;

      // 1: A,A,A -> exact price, no change; stray ready in IDLE is ignored
      drive_a(1'b1, 2'b01, 1'b0, 1'b1);
      tick();
      expect_a("s1_a1", 0, 0, -1, 0, 0, 1, 0);
      drive_a(1'b1, 2'b01, 1'b0, 1'b0);
      tick();
      expect_a("s1_a2", 0, 0, -1, 0, 0, 2, 0);
      tick();
      expect_a("s1_a3", 1, 0, -1, 0, 0, 3, 1);
      drive_a(1'b0, 2'b00, 1'b0, 1'b0);
      tick();
      expect_a("s1_done", 0, 0, -1, 0, 0, 0, 0);

      // 2 + 4: B then C -> change 4, held under backpressure; reject coin, ignore cancel
      drive_a(1'b1, 2'b10, 1'b0, 1'b0);
      tick();
      expect_a("s2_b", 0, 0, -1, 0, 0, 2, 0);
      drive_a(1'b1, 2'b11, 1'b0, 1'b0);
      tick();
      expect_a("s2_c", 1, 0, -1, 0, 0, 7, 1);
      drive_a(1'b0, 2'b00, 1'b0, 1'b0);
      tick();
      expect_a("s2_chg", 0, 1, 4, 0, 0, 7, 1);
      tick();
      expect_a("s2_hold1", 0, 1, 4, 0, 0, 7, 1);
      drive_a(1'b1, 2'b11, 1'b0, 1'b0);
      tick();
      expect_a("s4_rej", 0, 1, 4, 0, 1, 7, 1);
      drive_a(1'b0, 2'b00, 1'b1, 1'b0);
      tick();
      expect_a("s4_cancel", 0, 1, 4, 0, 0, 7, 1);
      drive_a(1'b0, 2'b00, 1'b0, 1'b1);
      tick();
      expect_a("s2_accept", 0, 0, -1, 0, 0, 0, 0);

      // 3: B, then cancel together with A -> refund 3, no vend even though price reached
      drive_a(1'b1, 2'b10, 1'b0, 1'b0);
      tick();
      expect_a("s3_b", 0, 0, -1, 0, 0, 2, 0);
      drive_a(1'b1, 2'b01, 1'b1, 1'b0);
      tick();
      expect_a("s3_refund", 0, 1, 3, 1, 0, 3, 1);
      drive_a(1'b0, 2'b00, 1'b0, 1'b1);
      tick();
      expect_a("s3_accept", 0, 0, -1, 0, 0, 0, 0);

      // 5: cancel with zero credit ignored; code 00 never credited
      drive_a(1'b0, 2'b00, 1'b1, 1'b0);
      tick();
      expect_a("s5_cancel0", 0, 0, -1, 0, 0, 0, 0);
      drive_a(1'b1, 2'b00, 1'b0, 1'b0);
      tick();
      expect_a("s5_code00", 0, 0, -1, 0, 0, 0, 0);
      drive_a(1'b1, 2'b01, 1'b0, 1'b0);
      tick();
      drive_a(1'b1, 2'b00, 1'b0, 1'b0);
      tick();
      expect_a("s5_code00_c1", 0, 0, -1, 0, 0, 1, 0);

      // 6: credit 1 + C = 6 -> vend, change 3; reset while change is pending
      drive_a(1'b1, 2'b11, 1'b0, 1'b0);
      tick();
      expect_a("s6_vend", 1, 0, -1, 0, 0, 6, 1);
      drive_a(1'b0, 2'b00, 1'b0, 1'b0);
      tick();
      expect_a("s6_chg", 0, 1, 3, 0, 0, 6, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_a("s6_reset", 0, 0, 0, 0, 0, 0, 0);
      drive_a(1'b1, 2'b01, 1'b0, 1'b0);
      tick();
      drive_a(1'b0, 2'b00, 1'b0, 1'b0);
      expect_a("s6_after_rst", 0, 0, -1, 0, 0, 1, 0);

      // 6b: wide build, C x4 -> 20 exactly, vend with no change
      b_if.coin_valid = 1'b1;
      b_if.coin_code  = 2'b11;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("s6b_c%0d.credit", i), 32'(b_if.credit), 32'(5 * i));
         chk($sformatf("s6b_c%0d.vend", i),   32'(b_if.vend),   32'(i == 4));
      end
      b_if.coin_valid = 1'b0;
      b_if.coin_code  = 2'b00;
      tick();
      chk("s6b_done.vend",      32'(b_if.vend),      32'd0);
      chk("s6b_done.chg_valid", 32'(b_if.chg_valid), 32'd0);
      chk("s6b_done.credit",    32'(b_if.credit),    32'd0);
      chk("s6b_done.busy",      32'(b_if.busy),      32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
